// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the IR pulse width meter.
// The record layout depends on the duration width, so it is declared
// inside pulse_width_meter as a packed struct.
package pulse_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    // Clock cycles that make up one reporting unit.
    function automatic int unsigned counts_per_unit(input int unsigned clk_mhz,
                                                    input int unsigned unit_us);
        return clk_mhz * unit_us;
    endfunction

endpackage

// File: rtl/unit_prescaler.sv
// Divides the clock into unit ticks. A restart marks the current cycle as the
// first cycle of a new unit, so a segment of L cycles collects floor(L/N) ticks.
module unit_prescaler #(
    parameter int unsigned COUNTS_PER_UNIT = 80
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic enable,
    input  logic restart,
    output logic tick
);
    localparam int CW = (COUNTS_PER_UNIT > 1) ? $clog2(COUNTS_PER_UNIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT    = CW'(COUNTS_PER_UNIT - 1);
    localparam logic [CW-1:0] AFTER_RESTART = (COUNTS_PER_UNIT > 1) ? CW'(1) : '0;

    logic [CW-1:0] count_reg;

    // The restart cycle itself is count 0 of the new unit.
    assign tick = enable && (restart ? (COUNTS_PER_UNIT == 1) : (count_reg == LAST_COUNT));

    // Free-running modulo-N cycle counter, realigned on restart.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            count_reg <= '0;
        end else if (!enable) begin
            count_reg <= '0;
        end else if (restart) begin
            count_reg <= AFTER_RESTART;
        end else if (count_reg == LAST_COUNT) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// IR mark/space duration meter. Each completed segment of the synchronized
// line becomes one {level, duration, overflow, last} record on a valid/ready
// output; an idle-level segment reaching TIMEOUT_UNITS closes the frame.
// Optional glitch filter: define PULSE_METER_GLITCH_FILTER_EN.
module pulse_width_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned UNIT_COUNTS_US = 10,
    parameter int unsigned CLK_MHZ        = 8,
    parameter logic        IDLE_LEVEL     = 1'b0,
    parameter int unsigned TIMEOUT_UNITS  = 1000
`ifdef PULSE_METER_GLITCH_FILTER_EN
    ,
    parameter int unsigned FILTER_CYCLES  = 4
`endif
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic             signal_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic             level_out,
    output logic [WIDTH-1:0] duration_out,
    output logic             overflow_out,
    output logic             last_out,
    output logic             overrun_out,
    output logic             busy_out
);
    localparam int unsigned      COUNTS_PER_UNIT = counts_per_unit(CLK_MHZ, UNIT_COUNTS_US);
    localparam logic [WIDTH-1:0] DURATION_MAX    = '1;
    localparam logic [WIDTH-1:0] TIMEOUT_VAL     = WIDTH'(TIMEOUT_UNITS);

    typedef struct packed {
        logic             level;
        logic [WIDTH-1:0] duration;
        logic             overflow;
        logic             last;
    } record_t;

    logic [1:0]       sync_reg;
    logic             line_sync;
    logic             line;
    logic             line_prev_reg;
    logic             edge_det;
    logic             edge_accept;
    logic             emit_edge;
    logic             emit_timeout;
    logic             emit;
    logic             tick;
    meter_state_t     state_reg;
    logic [WIDTH-1:0] count_reg;
    logic             sat_reg;
    record_t          emit_rec;
    record_t          rec_reg;
    logic             valid_reg;
    logic             overrun_reg;

    // Two-flop synchronizer for the asynchronous IR line; keeps running when disabled.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            sync_reg <= {2{IDLE_LEVEL}};
        end else begin
            sync_reg <= {sync_reg[0], signal_in};
        end
    end

    assign line_sync = sync_reg[1];

`ifdef PULSE_METER_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    logic [FW-1:0] stable_cnt_reg;
    logic          filt_reg;

    // Filtered level follows the line only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            filt_reg       <= IDLE_LEVEL;
            stable_cnt_reg <= '0;
        end else if (line_sync == filt_reg) begin
            stable_cnt_reg <= '0;
        end else if (stable_cnt_reg == FW'(FILTER_CYCLES - 1)) begin
            filt_reg       <= line_sync;
            stable_cnt_reg <= '0;
        end else begin
            stable_cnt_reg <= stable_cnt_reg + 1'b1;
        end
    end

    assign line = filt_reg;
`else
    assign line = line_sync;
`endif

    // Previous line level: edge reference and level of the segment just ended.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            line_prev_reg <= IDLE_LEVEL;
        end else begin
            line_prev_reg <= line;
        end
    end

    assign edge_det     = (line != line_prev_reg);
    // In IDLE only an edge leaving the idle level starts a measurement.
    assign edge_accept  = enable_in && edge_det && ((state_reg == MEASURE) || (line != IDLE_LEVEL));
    assign emit_edge    = enable_in && (state_reg == MEASURE) && edge_det;
    assign emit_timeout = enable_in && (state_reg == MEASURE) && !edge_det &&
                          (line == IDLE_LEVEL) && (count_reg == TIMEOUT_VAL);
    assign emit         = emit_edge || emit_timeout;

    unit_prescaler #(
        .COUNTS_PER_UNIT(COUNTS_PER_UNIT)
    ) u_prescaler (
        .clock_in(clock_in),
        .reset_in(reset_in),
        .enable  (enable_in),
        .restart (edge_accept),
        .tick    (tick)
    );

    // Record built from the segment that just ended, or the frame-end record.
    always_comb begin
        emit_rec = '0;
        if (emit_edge) begin
            emit_rec.level    = line_prev_reg;
            emit_rec.duration = count_reg;
            emit_rec.overflow = sat_reg;
            emit_rec.last     = 1'b0;
        end else begin
            emit_rec.level    = IDLE_LEVEL;
            emit_rec.duration = TIMEOUT_VAL;
            emit_rec.overflow = 1'b0;
            emit_rec.last     = 1'b1;
        end
    end

    // Measurement FSM with the saturating unit counter.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_reg <= IDLE;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (!enable_in) begin
            state_reg <= IDLE;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (edge_accept) begin
                        state_reg <= MEASURE;
                        count_reg <= '0;
                        sat_reg   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (emit_timeout) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                        sat_reg   <= 1'b0;
                    end else if (emit_edge) begin
                        count_reg <= '0;
                        sat_reg   <= 1'b0;
                    end else if (tick) begin
                        if (count_reg == DURATION_MAX) begin
                            sat_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Single-entry output register; a record arriving while one is stalled is dropped.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            rec_reg     <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (!enable_in) begin
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (emit && (!valid_reg || ready_in)) begin
                rec_reg   <= emit_rec;
                valid_reg <= 1'b1;
            end else if (ready_in) begin
                valid_reg <= 1'b0;
            end
            if (emit && valid_reg && !ready_in) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign valid_out    = valid_reg;
    assign level_out    = rec_reg.level;
    assign duration_out = rec_reg.duration;
    assign overflow_out = rec_reg.overflow;
    assign last_out     = rec_reg.last;
    assign overrun_out  = overrun_reg;
    assign busy_out     = (state_reg == MEASURE);

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: 80 cycles per unit, TIMEOUT_UNITS=20
// on the main instance, plus a WIDTH=4 instance for saturation.
module tb_pulse_width_meter;

    localparam int CPU = 80;
`ifdef PULSE_METER_GLITCH_FILTER_EN
    localparam int EXP_LAT = 7;
`else
    localparam int EXP_LAT = 3;
`endif

    typedef struct {
        int level;
        int dur;
        int ovf;
        int last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, ready, sig, sig_b;

    logic        valid_a, level_a, ovf_a, last_a, overrun_a, busy_a;
    logic [15:0] dur_a;
    logic        valid_b, level_b, ovf_b, last_b, overrun_b, busy_b;
    logic [3:0]  dur_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pulse_width_meter #(
        .WIDTH(16), .UNIT_COUNTS_US(10), .CLK_MHZ(8), .IDLE_LEVEL(1'b0), .TIMEOUT_UNITS(20)
    ) dut_a (
        .clock_in(clk), .reset_in(rst), .enable_in(enable), .signal_in(sig), .ready_in(ready),
        .valid_out(valid_a), .level_out(level_a), .duration_out(dur_a), .overflow_out(ovf_a),
        .last_out(last_a), .overrun_out(overrun_a), .busy_out(busy_a)
    );

    pulse_width_meter #(
        .WIDTH(4), .UNIT_COUNTS_US(10), .CLK_MHZ(8), .IDLE_LEVEL(1'b0), .TIMEOUT_UNITS(10)
    ) dut_b (
        .clock_in(clk), .reset_in(rst), .enable_in(enable), .signal_in(sig_b), .ready_in(1'b1),
        .valid_out(valid_b), .level_out(level_b), .duration_out(dur_b), .overflow_out(ovf_b),
        .last_out(last_b), .overrun_out(overrun_b), .busy_out(busy_b)
    );

    task automatic check_value(input string tag, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Expected record for a segment of n cycles, saturated to maxv.
    function automatic exp_t mk_seg(input int lvl, input int n, input int maxv);
        exp_t e;
        e.level = lvl;
        e.dur   = (n / CPU > maxv) ? maxv : n / CPU;
        e.ovf   = (n / CPU > maxv) ? 1 : 0;
        e.last  = 0;
        return e;
    endfunction

    function automatic exp_t mk_timeout(input int units);
        exp_t e;
        e.level = 0;
        e.dur   = units;
        e.ovf   = 0;
        e.last  = 1;
        return e;
    endfunction

    // Compare every accepted record against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && valid_a && ready) begin
            if (q_a.size() == 0) begin
                check_value("a_unexpected_record", valid_a, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                $display("rec A: level=%0d dur=%0d ovf=%0d last=%0d", level_a, dur_a, ovf_a, last_a);
                check_value("a_level", level_a, e.level);
                check_value("a_duration", dur_a, e.dur);
                check_value("a_overflow", ovf_a, e.ovf);
                check_value("a_last", last_a, e.last);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_b) begin
            if (q_b.size() == 0) begin
                check_value("b_unexpected_record", valid_b, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                $display("rec B: level=%0d dur=%0d ovf=%0d last=%0d", level_b, dur_b, ovf_b, last_b);
                check_value("b_level", level_b, e.level);
                check_value("b_duration", dur_b, e.dur);
                check_value("b_overflow", ovf_b, e.ovf);
                check_value("b_last", last_b, e.last);
            end
        end
    end

    // Hold sig at lvl for n sampling edges; returns 1 time unit after the last edge.
    task automatic seg(input logic lvl, input int n);
        sig = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a scoreboard queue to empty.
    task automatic drain(input string tag, input bit which_b, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if ((which_b ? q_b.size() : q_a.size()) == 0) break;
            @(posedge clk);
        end
        #1;
        check_value(tag, which_b ? q_b.size() : q_a.size(), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst = 1'b1; enable = 1'b1; ready = 1'b1; sig = 1'b0; sig_b = 1'b0;
        cycles(3);
        check_value("reset_valid", valid_a, 0);
        check_value("reset_duration", dur_a, 0);
        check_value("reset_overrun", overrun_a, 0);
        check_value("reset_busy", busy_a, 0);
        rst = 1'b0;
        cycles(5);

        // Mark 800, space 400, mark 160, then idle until frame timeout.
        seg(1'b1, 800);
        check_value("t1_busy_in_mark", busy_a, 1);
        q_a.push_back(mk_seg(1, 800, 65535));
        seg(1'b0, 400);
        q_a.push_back(mk_seg(0, 400, 65535));
        seg(1'b1, 160);
        q_a.push_back(mk_seg(1, 160, 65535));
        q_a.push_back(mk_timeout(20));
        sig = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (valid_a) begin lat = k; break; end
        end
        check_value("t1_edge_latency", lat, EXP_LAT);
        drain("t1_drain", 1'b0, 2000);
        cycles(2);
        check_value("t1_busy_after_timeout", busy_a, 0);

        // Stalled consumer: second record dropped, first held, overrun sticky.
        ready = 1'b0;
        seg(1'b1, 800);
        q_a.push_back(mk_seg(1, 800, 65535));
        seg(1'b0, 400);
        sig = 1'b1;
        cycles(10);
        check_value("t2_valid_held", valid_a, 1);
        check_value("t2_level_held", level_a, 1);
        check_value("t2_duration_held", dur_a, 10);
        check_value("t2_overrun", overrun_a, 1);
        ready = 1'b1;
        cycles(1);
        check_value("t2_valid_drop", valid_a, 0);
        check_value("t2_queue", q_a.size(), 0);
        enable = 1'b0;
        cycles(1);
        check_value("t2_overrun_cleared", overrun_a, 0);
        check_value("t2_busy_cleared", busy_a, 0);
        sig = 1'b0;
        cycles(10);
        enable = 1'b1;
        cycles(5);

        // enable_in dropped mid-mark aborts silently.
        seg(1'b1, 300);
        check_value("t3_busy_before", busy_a, 1);
        enable = 1'b0;
        cycles(1);
        check_value("t3_valid", valid_a, 0);
        check_value("t3_busy", busy_a, 0);
        check_value("t3_overrun", overrun_a, 0);
        sig = 1'b0;
        cycles(20);
        // Re-enable while the line is active: must not start a measurement.
        sig = 1'b1;
        cycles(10);
        enable = 1'b1;
        cycles(20);
        check_value("t3_active_at_enable", busy_a, 0);
        sig = 1'b0;
        cycles(20);
        check_value("t3_fall_after_enable", busy_a, 0);
        check_value("t3_no_record", valid_a, 0);

        // Saturation on the WIDTH=4 instance: 20-unit mark.
        sig_b = 1'b1;
        cycles(1600);
        q_b.push_back(mk_seg(1, 1600, 15));
        q_b.push_back(mk_timeout(10));
        sig_b = 1'b0;
        drain("t4_drain", 1'b1, 1200);
        check_value("t4_busy_b", busy_b, 0);

        // Two-cycle glitch on an idle line.
        seg(1'b1, 2);
        sig = 1'b0;
`ifndef PULSE_METER_GLITCH_FILTER_EN
        q_a.push_back(mk_seg(1, 2, 65535));
        q_a.push_back(mk_timeout(20));
        cycles(10);
        check_value("t5_busy", busy_a, 1);
`else
        cycles(10);
        check_value("t5_busy", busy_a, 0);
`endif
        drain("t5_drain", 1'b0, 2000);
        cycles(5);

        // Asynchronous reset while a record is held and a segment is running.
        ready = 1'b0;
        seg(1'b1, 800);
        sig = 1'b0;
        cycles(200);
        check_value("t6_valid_before", valid_a, 1);
        check_value("t6_busy_before", busy_a, 1);
        #2;
        rst = 1'b1;
        #1;
        check_value("t6_valid_reset", valid_a, 0);
        check_value("t6_busy_reset", busy_a, 0);
        check_value("t6_duration_reset", dur_a, 0);
        check_value("t6_level_reset", level_a, 0);
        cycles(2);
        rst = 1'b0;
        ready = 1'b1;
        cycles(2000);
        check_value("t6_no_record", valid_a, 0);
        check_value("t6_busy_idle", busy_a, 0);
        check_value("t6_queue", q_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Measures the mark and space durations of a demodulated IR input line in time units. It is the capture-side counterpart of the delay-timed IR transmit path. Each completed segment is emitted as one record: level, duration in units, and a saturation flag. Records pass over a valid/ready handshake to the code-learning logic, and a frame end is flagged after an idle timeout.

## Interface
- WIDTH, 16, duration field width in units
- UNIT_COUNTS_US, 10, unit length in µs
- CLK_MHZ, 8, clock frequency; COUNTS_PER_UNIT = CLK_MHZ*UNIT_COUNTS_US
- IDLE_LEVEL, 0, line level when no carrier is present (space)
- TIMEOUT_UNITS, 1000, idle-level duration that ends a frame (must be < 2^WIDTH-1)
- FILTER_CYCLES, 4, stability window of the glitch filter (macro-dependent)
- clock_in  in  1  clock
- reset_in  in  1  asynchronous, active-high reset
- enable_in  in  1  measurement enabled when high; low synchronously clears to IDLE
- signal_in  in  1  asynchronous IR line
- ready_in  in  1  consumer accepts a record
- valid_out  out  1  record available
- level_out  out  1  line level of the reported segment
- duration_out  out  WIDTH  segment length in whole units
- overflow_out  out  1  duration saturated
- last_out  out  1  record closes the frame (timeout)
- overrun_out  out  1  sticky: a record was dropped
- busy_out  out  1  FSM in MEASURE

## Operation
- signal_in passes a 2-FF synchronizer (reset value IDLE_LEVEL). A registered copy gives edge detection.
- FSM states:
  - IDLE to MEASURE on an edge leaving IDLE_LEVEL.
  - MEASURE to IDLE on timeout or when enable_in is low.
  - No record is produced on IDLE to MEASURE.
- Prescaler (COUNTS_PER_UNIT-cycle period) restarts at every accepted edge. Its tick increments the unit counter, which saturates at 2^WIDTH-1 and sets an internal sat flag.
- Edge in MEASURE: emit {level=previous line level, duration=counter, overflow=sat, last=0}. Then clear counter and sat, and restart the prescaler.
- Timeout: in MEASURE with the line at IDLE_LEVEL and counter == TIMEOUT_UNITS, emit {IDLE_LEVEL, TIMEOUT_UNITS, 0, last=1} and go to IDLE.
- A segment of L cycles reports floor(L/COUNTS_PER_UNIT), saturated.
- Output register: loads on emit when !valid_out, or when valid_out && ready_in in the same cycle (replace). valid_out clears on ready_in with no new emit.
- Emit while valid_out && !ready_in: the new record is dropped, the held record is unchanged, and overrun_out is set.
- enable_in low clears:
  - FSM, counters, valid_out and overrun_out.
  - The synchronizer still runs.
- No emit or edge detection occurs while enable_in is low. Enabling with the line at the active level waits for idle first; a non-idle level at enable is not an edge.

## Timing
- All outputs reset to 0.
- valid_out rises 3 clock edges after a signal_in transition: 2 sync, 1 output register.
- The held record is stable until the cycle after the ready_in handshake.
- Timeout record: valid_out rises 1 edge after the tick that makes counter == TIMEOUT_UNITS.
- Reset mid-measurement aborts without a record.

## Configuration
- PULSE_METER_GLITCH_FILTER_EN defined:
  - The synchronized line feeds a filter that changes state only after FILTER_CYCLES consecutive equal samples.
  - Latency to valid_out is 3+FILTER_CYCLES edges.
  - Pulses shorter than FILTER_CYCLES are ignored.
- Not defined: no filter, every synchronized edge counts, and FILTER_CYCLES is unused.

## Structure
- pulse_meter_pkg: FSM state enum (IDLE, MEASURE) and a record struct with fields level, duration, overflow, last. Width is handled by a parameterized typedef or a packed layout in the module.
- Sub-module unit_prescaler:
  - Inputs: restart, enable.
  - Output: tick, a one-cycle pulse every COUNTS_PER_UNIT cycles.

## Test plan
All cases use CLK_MHZ=8, UNIT_COUNTS_US=10 (80 cycles/unit), TIMEOUT_UNITS=20, ready_in=1 unless stated.
- Reset asserted mid-segment: all outputs are 0 immediately (asynchronous) and no record appears after release.
- Mark 800 cycles, space 400, mark 160, then idle: records (1,10,0,0), (0,5,0,0), (1,2,0,0), (0,20,0,last=1), busy_out then 0.
- ready_in held 0 across mark 800 and space 400: valid_out holds (1,10); overrun_out=1. When ready_in rises, valid_out drops the next cycle.
- WIDTH=4 with a mark of 20 units: record (1,15,overflow=1).
- enable_in dropped 300 cycles into a mark: valid_out, busy_out and overrun_out read 0 the next cycle, and there is no record.
- 2-cycle high glitch on idle line:
  - With the macro: no record.
  - Without the macro: MEASURE is entered, then record (1,0,0,0) is emitted.
